// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: fixed encodings, the branch-predictor
// counter type and its reset value, and the B-type immediate decoder.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h00000013;
  localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_WNT = 2'b01;

  // Sign-extended B-type immediate: {imm[12], imm[11], imm[10:5], imm[4:1], 0}.
  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/riscv_bht.sv
// Branch history table: an array of 2-bit saturating counters indexed by
// pc[log2(ENTRIES)+1:2].
//   clk, rst      clock, synchronous active-high reset (all counters -> BHT_WNT)
//   rd_pc         PC looked up by the fetch stage
//   rd_ctr        counter for rd_pc (combinational; returns pre-update value)
//   upd_en        apply a resolved outcome this cycle
//   upd_pc        PC of the resolved branch
//   upd_taken     resolved outcome (+1 if taken, -1 otherwise, saturating)
module riscv_bht
  import riscv_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic [1:0]  rd_ctr,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  function automatic logic [IDX_W-1:0] idx(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  bht_ctr_t ctr_q [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  bht_ctr_t         upd_cur;
  bht_ctr_t         upd_nxt;

  assign rd_idx  = idx(rd_pc);
  assign upd_idx = idx(upd_pc);
  assign rd_ctr  = ctr_q[rd_idx];
  assign upd_cur = ctr_q[upd_idx];

  always_comb begin
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= BHT_WNT;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= upd_nxt;
    end
  end

  // Only the index bits of the PCs select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[31:IDX_W+2], rd_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

endmodule

// File: rtl/riscv_fetch_bp.sv
// Fetch stage (IF + IF/ID register) with a 2-bit dynamic branch predictor.
//   clk, rst        clock, synchronous active-high reset
//   imem_addr       fetch PC to instruction memory; imem_rd returns the word same cycle
//   stall_f/_d      hold the fetch PC / the IF/ID register
//   ex_*            branch/jump resolution from execute
//   instr_d, pc_d, pc_plus4_d, pred_taken_d   IF/ID register contents
//   redirect        combinational mispredict/jump indication for the hazard unit
module riscv_fetch_bp
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter bit          PREDICT     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        ex_br,
  input  logic        ex_jump,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        pred_taken_d,
  output logic        redirect
);

  logic [31:0] pc_f_q;
  logic [31:0] instr_q, pc_q, pc_plus4_q;
  logic        pred_q;

  logic [1:0]  bht_rd;
  logic        br_f, pred_f;
  logic [31:0] pc_plus4_f, pred_target, next_pc, fix_pc;
  logic        bht_upd;

  // A jump alongside a branch is treated purely as a jump: no counter update.
  assign bht_upd = ex_br & ~ex_jump;

  riscv_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pc_f_q),
    .rd_ctr    (bht_rd),
    .upd_en    (bht_upd),
    .upd_pc    (ex_pc),
    .upd_taken (ex_taken)
  );

  assign imem_addr   = pc_f_q;
  assign br_f        = (imem_rd[6:0] == OPCODE_BRANCH);
  assign pred_f      = PREDICT && br_f && bht_rd[1];
  assign pc_plus4_f  = pc_f_q + 32'd4;
  assign pred_target = pc_f_q + b_imm(imem_rd);
  assign next_pc     = pred_f ? pred_target : pc_plus4_f;

  assign redirect = ex_jump | (ex_br & (ex_taken != ex_pred_taken));
  assign fix_pc   = (ex_jump | ex_taken) ? ex_target : ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q     <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      pred_q     <= 1'b0;
    end else if (redirect) begin
      pc_f_q     <= fix_pc;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      pred_q     <= 1'b0;
    end else begin
      if (!stall_f) pc_f_q <= next_pc;
      if (!stall_d) begin
        instr_q    <= imem_rd;
        pc_q       <= pc_f_q;
        pc_plus4_q <= pc_plus4_f;
        pred_q     <= pred_f;
      end
    end
  end

  assign instr_d      = instr_q;
  assign pc_d         = pc_q;
  assign pc_plus4_d   = pc_plus4_q;
  assign pred_taken_d = pred_q;

endmodule

// File: tb/tb_riscv_fetch_bp.sv
module tb_riscv_fetch_bp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rd;
  logic        stall_f = 1'b0, stall_d = 1'b0;
  logic        ex_br = 1'b0, ex_jump = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        pred_taken_d, redirect;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [64];

  always #5 clk = ~clk;

  assign imem_rd = imem[imem_addr[7:2]];

  riscv_fetch_bp #(
    .RESET_PC    (32'h0),
    .BHT_ENTRIES (16),
    .PREDICT     (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .ex_br         (ex_br),
    .ex_jump       (ex_jump),
    .ex_taken      (ex_taken),
    .ex_pred_taken (ex_pred_taken),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .pc_plus4_d    (pc_plus4_d),
    .pred_taken_d  (pred_taken_d),
    .redirect      (redirect)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_br = 0; ex_jump = 0; ex_taken = 0; ex_pred_taken = 0; ex_pc = '0; ex_target = '0;
  endtask

  task automatic do_reset();
    rst = 1; stall_f = 0; stall_d = 0;
    clear_ex();
    tick();
    rst = 0;
  endtask

  // Train bht[0] from 01 to 10 while fetch holds at pc 0; IF/ID captures the
  // beq with the pre-update prediction.
  task automatic train_idx0();
    stall_f = 1; stall_d = 0;
    ex_br = 1; ex_taken = 1; ex_pred_taken = 1; ex_pc = 32'h0;
    tick();
    clear_ex();
    stall_f = 0;
  endtask

  task automatic test_reset();
    bit all_wnt;
    do_reset();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, 32'h0); end
    checks++; if (instr_d !== 32'h13) begin errors++; $display("FAIL reset_instr got %h want %h", instr_d, 32'h13); end
    checks++; if ({pc_d, pc_plus4_d, pred_taken_d} !== 65'h0) begin errors++; $display("FAIL reset_ifid got %h/%h/%b want 0/0/0", pc_d, pc_plus4_d, pred_taken_d); end
    all_wnt = 1;
    for (int i = 0; i < 16; i++) if (dut.u_bht.ctr_q[i] !== 2'b01) all_wnt = 0;
    checks++; if (!all_wnt) begin errors++; $display("FAIL reset_bht got non-01 entry want all 01"); end
  endtask

  task automatic test_mispredict_taken();
    do_reset();
    tick();
    checks++; if (imem_addr !== 32'h4 || instr_d !== 32'h00208a63 || pred_taken_d !== 1'b0) begin errors++; $display("FAIL t1_fetch got %h/%h/%b want 4/00208a63/0", imem_addr, instr_d, pred_taken_d); end
    tick();
    checks++; if (imem_addr !== 32'h8 || instr_d !== 32'h00100093 || pc_d !== 32'h4) begin errors++; $display("FAIL t1_seq got %h/%h/%h want 8/00100093/4", imem_addr, instr_d, pc_d); end
    ex_br = 1; ex_taken = 1; ex_pred_taken = 0; ex_pc = 32'h0; ex_target = 32'h14;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL t1_redirect got %b want 1", redirect); end
    tick();
    clear_ex();
    checks++; if (imem_addr !== 32'h14 || instr_d !== 32'h13 || pc_d !== 32'h0) begin errors++; $display("FAIL t1_flush got %h/%h/%h want 14/13/0", imem_addr, instr_d, pc_d); end
    checks++; if (dut.u_bht.ctr_q[0] !== 2'b10) begin errors++; $display("FAIL t1_bht got %b want 10", dut.u_bht.ctr_q[0]); end
  endtask

  task automatic test_predict_taken();
    do_reset();
    train_idx0();
    checks++; if (imem_addr !== 32'h0 || pred_taken_d !== 1'b0 || instr_d !== 32'h00208a63) begin errors++; $display("FAIL t2_oldread got %h/%b/%h want 0/0/00208a63", imem_addr, pred_taken_d, instr_d); end
    tick();
    checks++; if (imem_addr !== 32'h14 || pred_taken_d !== 1'b1 || pc_d !== 32'h0 || pc_plus4_d !== 32'h4) begin errors++; $display("FAIL t2_pred got %h/%b/%h/%h want 14/1/0/4", imem_addr, pred_taken_d, pc_d, pc_plus4_d); end
    tick();
    ex_br = 1; ex_taken = 1; ex_pred_taken = 1; ex_pc = 32'h0; ex_target = 32'h14;
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL t2_noredirect got %b want 0", redirect); end
    tick();
    clear_ex();
    checks++; if (imem_addr !== 32'h1c || dut.u_bht.ctr_q[0] !== 2'b11) begin errors++; $display("FAIL t2_next got %h/%b want 1c/11", imem_addr, dut.u_bht.ctr_q[0]); end
  endtask

  task automatic test_mispredict_not_taken();
    do_reset();
    train_idx0();
    tick();
    tick();
    ex_br = 1; ex_taken = 0; ex_pred_taken = 1; ex_pc = 32'h0; ex_target = 32'h14;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL t3_redirect got %b want 1", redirect); end
    tick();
    clear_ex();
    checks++; if (imem_addr !== 32'h4 || instr_d !== 32'h13 || pred_taken_d !== 1'b0) begin errors++; $display("FAIL t3_fix got %h/%h/%b want 4/13/0", imem_addr, instr_d, pred_taken_d); end
    checks++; if (dut.u_bht.ctr_q[0] !== 2'b01) begin errors++; $display("FAIL t3_bht got %b want 01", dut.u_bht.ctr_q[0]); end
  endtask

  task automatic test_stall_jump();
    do_reset();
    tick();
    tick();
    stall_f = 1; stall_d = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h8 || instr_d !== 32'h00100093 || pc_d !== 32'h4) begin errors++; $display("FAIL t4_hold%0d got %h/%h/%h want 8/00100093/4", i, imem_addr, instr_d, pc_d); end
    end
    // Branch and jump together: the jump wins and the counter stays put.
    ex_jump = 1; ex_br = 1; ex_taken = 0; ex_pred_taken = 0; ex_pc = 32'h8; ex_target = 32'h40;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL t4_redirect got %b want 1", redirect); end
    tick();
    clear_ex();
    stall_f = 0; stall_d = 0;
    checks++; if (imem_addr !== 32'h40 || instr_d !== 32'h13) begin errors++; $display("FAIL t4_jump got %h/%h want 40/13", imem_addr, instr_d); end
    checks++; if (dut.u_bht.ctr_q[2] !== 2'b01) begin errors++; $display("FAIL t4_bht got %b want 01", dut.u_bht.ctr_q[2]); end
  endtask

  task automatic test_saturation();
    do_reset();
    stall_f = 1; stall_d = 1;
    ex_br = 1; ex_taken = 1; ex_pred_taken = 1; ex_pc = 32'h24;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (dut.u_bht.ctr_q[9] !== 2'b11) begin errors++; $display("FAIL t5_sat got %b want 11", dut.u_bht.ctr_q[9]); end
    ex_taken = 0; ex_pred_taken = 0;
    tick();
    checks++; if (dut.u_bht.ctr_q[9] !== 2'b10) begin errors++; $display("FAIL t5_dec got %b want 10", dut.u_bht.ctr_q[9]); end
    clear_ex();
    ex_jump = 1; ex_target = 32'h24;
    tick();
    clear_ex();
    stall_f = 0; stall_d = 0;
    checks++; if (imem_addr !== 32'h24) begin errors++; $display("FAIL t5_jump got %h want 24", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h38 || pred_taken_d !== 1'b1 || pc_d !== 32'h24) begin errors++; $display("FAIL t5_pred got %h/%b/%h want 38/1/24", imem_addr, pred_taken_d, pc_d); end
  endtask

  task automatic test_reset_with_redirect();
    bit all_wnt;
    do_reset();
    ex_br = 1; ex_taken = 1; ex_pred_taken = 1; ex_pc = 32'hc;
    tick();
    rst = 1;
    ex_br = 1; ex_taken = 1; ex_pred_taken = 0; ex_pc = 32'h0; ex_target = 32'h40;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL t6_redirect got %b want 1", redirect); end
    tick();
    rst = 0;
    clear_ex();
    checks++; if (imem_addr !== 32'h0 || instr_d !== 32'h13 || pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin errors++; $display("FAIL t6_state got %h/%h/%h/%h want 0/13/0/0", imem_addr, instr_d, pc_d, pc_plus4_d); end
    all_wnt = 1;
    for (int i = 0; i < 16; i++) if (dut.u_bht.ctr_q[i] !== 2'b01) all_wnt = 0;
    checks++; if (!all_wnt) begin errors++; $display("FAIL t6_bht got non-01 entry want all 01"); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h00000013;
    imem[0] = 32'h00208a63;  // beq x1,x2,+20
    imem[1] = 32'h00100093;  // addi x1,x0,1
    imem[2] = 32'h00200113;  // addi x2,x0,2
    imem[9] = 32'h00208a63;  // beq at 0x24 -> 0x38
    test_reset();
    test_mispredict_taken();
    test_predict_taken();
    test_mispredict_not_taken();
    test_stall_jump();
    test_saturation();
    test_reset_with_redirect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
